hazard_ctrl_n: RTL
==================

// Module: hazard_ctrl_n
// PURPOSE
//  Parametrised pipeline hazard controller for the RISC-V core, the successor to the fixed 5-stage hazard unit.
//  Keeps its own shadow scoreboard of {valid, rd, regwrite, isload, ra1, ra2} for stage E and NSTAGES later stages.
//  From that scoreboard it drives forwarding selects, load-use stalls, control-change flushes and a whole-pipe freeze
//  while data memory is not ready. It also gates the regfile write and counts retired instructions.
// PARAMETERS
//  NSTAGES   2   stages after E (1=M ... NSTAGES=W); range 1..6
//  LOAD_LAT  1   stages after E before load data is forwardable; range 0..NSTAGES-1
//  REGBITS   5   register index width
//  CNT_W     32  width of the retire counter
//  FW_W      $clog2(NSTAGES+1)  forward-select width (localparam)
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        synchronous, active-high
//  ra1D, ra2D      in   REGBITS  source registers of the instruction in D
//  use1D, use2D    in   1        D instruction actually reads ra1D / ra2D
//  rdD             in   REGBITS  destination register in D
//  regwriteD       in   1        D instruction writes rdD
//  memtoregD       in   1        D instruction is a load
//  validD          in   1        D slot holds a real instruction (not a bubble)
//  controlChangeE  in   1        taken branch or jump resolved in E
//  mem_ready       in   1        data memory completes this cycle (0 = stall)
//  stallF, stallD  out  1        hold the PC register / the F->D register
//  flushD, flushE  out  1        clear the F->D register / the D->E register
//  stallB          out  1        freeze E and all later pipe registers
//  forwardAE/BE    out  FW_W     0 = regfile; k = result of stage k (1..NSTAGES)
//  wb_enW          out  1        regfile write enable (regwrite of last stage, gated)
//  instret         out  CNT_W    retired-instruction count
// BEHAVIOUR
//  Scoreboard: entries s[0]=E ... s[NSTAGES]=last stage. Each entry is {v, rd, rw, ld, ra1, ra2}.
//   - On a clock edge with stallB=0, every entry shifts down one stage: s[k] <= s[k-1].
//   - s[0] is then loaded from D if flushE=0, or with a bubble (v=0) if flushE=1.
//   - With stallB=1, all entries hold their value.
//  Forwarding (combinational, operand A; operand B identical using ra2):
//   - Select the smallest k in 1..NSTAGES where s[k].v & s[k].rw & s[k].rd==s[0].ra1, s[0].ra1!=0,
//     and (!s[k].ld | k>=LOAD_LAT+1). The youngest producer wins.
//   - If no entry matches, the select is 0.
//   - A bubble in E (s[0].v=0) drives 0.
//  Load-use hazard luse=1 when, for some j in 0..LOAD_LAT-1:
//   - s[j].v & s[j].ld & s[j].rw & s[j].rd!=0, and
//   - (use1D & ra1D==s[j].rd) | (use2D & ra2D==s[j].rd), and
//   - validD=1.
//   With LOAD_LAT=0, luse is always 0.
//  Memory stall: mstall = !mem_ready & (some s[k].v & s[k].ld, or a store in M). To keep it simple, mstall = !mem_ready.
//  Output priority, per cycle:
//   - mstall:        stallF=stallD=stallB=1, flushD=flushE=0.
//   - controlChangeE: flushD=flushE=1, stallF=stallD=0. Also takes priority over luse; the stalled instruction is squashed.
//   - luse:          stallF=stallD=1, flushE=1, flushD=0.
//   - otherwise:     all 0.
//  Under mstall, controlChangeE is held because E is frozen. Its flush fires on the first cycle with mem_ready=1.
//  wb_enW = s[NSTAGES].v & s[NSTAGES].rw & !mstall. The last stage never writes twice while frozen.
//  instret increments by 1 on each edge with stallB=0 and s[NSTAGES].v=1. It wraps modulo 2^CNT_W.
//  rd==0 is never a forwarding source or a stall cause, but it does retire.
//  Reset (edge with reset=1):
//   - All scoreboard entries are cleared (v=0) and instret is set to 0.
//   - While reset is high: flushD=flushE=1, stalls=0, forward selects=0, wb_enW=0.
//   - Reset mid-stall discards in-flight state; the first cycle after reset behaves as an empty pipe.
//  Latency: forwarding and stall decisions are purely combinational on the current scoreboard and D inputs,
//   so there are no extra pipeline cycles.
// TESTING
//  T1 ALU chain, defaults: addi x1; then add x2,x1,x1 -> forwardAE=forwardBE=1 in E, no stall.
//     Filler then a 3rd user -> select 2.
//  T2 Load-use, defaults: lw x5 then add x6,x5,x0 -> one cycle of stallF=stallD=flushE=1, then forwardAE=2, no flushD.
//  T3 Load-use with NSTAGES=4, LOAD_LAT=2: lw x5; add x6,x5 -> stall 2 cycles, then forwardAE=3.
//     With one independent instruction in between -> stall 1 cycle.
//  T4 Control change during luse: lw x5 in E asserting controlChangeE, use of x5 in D
//     -> flushD=flushE=1, stallF=0, no stall cycle.
//  T5 Memory stall: mem_ready=0 for 3 cycles with a valid regwrite in W -> stallB=1, wb_enW=0 for 3 cycles.
//     Scoreboard and instret frozen; wb_enW=1 exactly once afterwards. A pending controlChangeE flushes after release.
//  T6 Reset and x0: reset mid-stall -> all outputs at reset values and instret=0.
//     Writes to x0 then reads of x0 -> selects 0, no stall. Retire 10 instructions -> instret=10.

Source files
------------

// File: rtl/hazard_ctrl_n.sv
// Parametrised hazard controller with a private shadow scoreboard of E and the NSTAGES stages after it.
// Drives forwarding selects, load-use stalls, control-change flushes, memory freezes, WB gating and retire count.
module hazard_ctrl_n #(
    parameter  int NSTAGES  = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int REGBITS  = 5,
    parameter  int CNT_W    = 32,
    localparam int FW_W     = $clog2(NSTAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] ra1D,
    input  logic [REGBITS-1:0] ra2D,
    input  logic               use1D,
    input  logic               use2D,
    input  logic [REGBITS-1:0] rdD,
    input  logic               regwriteD,
    input  logic               memtoregD,
    input  logic               validD,
    input  logic               controlChangeE,
    input  logic               mem_ready,
    output logic               stallF,
    output logic               stallD,
    output logic               flushD,
    output logic               flushE,
    output logic               stallB,
    output logic [FW_W-1:0]    forwardAE,
    output logic [FW_W-1:0]    forwardBE,
    output logic               wb_enW,
    output logic [CNT_W-1:0]   instret
);

    typedef struct packed {
        logic               v;
        logic [REGBITS-1:0] rd;
        logic               rw;
        logic               ld;
        logic [REGBITS-1:0] ra1;
        logic [REGBITS-1:0] ra2;
    } sb_ent_t;

    sb_ent_t [NSTAGES:0] sb_q, sb_d;
    logic    [CNT_W-1:0] instret_q, instret_d;
    logic                luse, mstall;

    // Scan oldest to youngest so the youngest eligible producer overwrites.
    function automatic logic [FW_W-1:0] fwd_sel(input logic [REGBITS-1:0] ra,
                                                input sb_ent_t [NSTAGES:0] sb);
        logic [FW_W-1:0] sel;
        sel = '0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (sb[k].v && sb[k].rw && sb[k].rd == ra && (!sb[k].ld || k >= LOAD_LAT + 1))
                sel = FW_W'(k);
        end
        if (!sb[0].v || ra == '0)
            sel = '0;
        return sel;
    endfunction

    assign mstall = !mem_ready;

    always_comb begin
        luse = 1'b0;
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (sb_q[j].v && sb_q[j].ld && sb_q[j].rw && sb_q[j].rd != '0 && validD &&
                ((use1D && ra1D == sb_q[j].rd) || (use2D && ra2D == sb_q[j].rd)))
                luse = 1'b1;
        end
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        stallB    = 1'b0;
        forwardAE = '0;
        forwardBE = '0;
        wb_enW    = 1'b0;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else begin
            forwardAE = fwd_sel(sb_q[0].ra1, sb_q);
            forwardBE = fwd_sel(sb_q[0].ra2, sb_q);
            wb_enW    = sb_q[NSTAGES].v && sb_q[NSTAGES].rw && !mstall;
            // A control change waits behind the freeze because E is held with it.
            if (mstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallB = 1'b1;
            end else if (controlChangeE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (luse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_comb begin
        sb_d      = sb_q;
        instret_d = instret_q;
        if (!stallB) begin
            for (int k = 1; k <= NSTAGES; k++)
                sb_d[k] = sb_q[k-1];
            sb_d[0] = flushE ? '0 : {validD, rdD, regwriteD, memtoregD, ra1D, ra2D};
            if (sb_q[NSTAGES].v)
                instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q      <= '0;
            instret_q <= '0;
        end else begin
            sb_q      <= sb_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule
